// File: rtl/seq_divider_64.sv
// 64-bit sequential restoring divider, one quotient bit per cycle, with signed/unsigned
// operands and single-cycle bypass for divide-by-zero and signed overflow.
module seq_divider_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [6:0]  LAST_IT  = 7'd63;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        busy_r;
  logic        done_r;
  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic [63:0] quotient_r;
  logic [63:0] remainder_r;
  logic        div_by_zero_r;
  logic        overflow_r;

  logic [63:0] acc_r;
  logic [63:0] dq_r;
  logic [63:0] div_r;
  logic        neg_q_r;
  logic        neg_rem_r;
  logic [6:0]  cnt_r;

  logic        accept_s;
  logic        zero_div_s;
  logic        ovf_case_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [64:0] shifted_s;
  logic [64:0] diff_s;
  logic        q_bit_s;

  function automatic logic [63:0] cond_negate(input logic [63:0] v, input logic neg);
    cond_negate = neg ? (64'd0 - v) : v;
  endfunction

  // Operand classification and the single restoring-division step.
  always_comb begin
    accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    zero_div_s = (divisor == 64'd0);
    ovf_case_s = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
    a_neg_s    = is_signed & dividend[63];
    b_neg_s    = is_signed & divisor[63];
    shifted_s  = {acc_r, dq_r[63]};
    diff_s     = shifted_s - {1'b0, div_r};
    q_bit_s    = ~diff_s[64];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; special operands skip straight to DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (zero_div_s || ovf_case_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_IT) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status flags decoded from the upcoming state so they can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      CALC, FIX: busy_nxt_s = 1'b1;
      DONE:      done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Datapath: operand capture, iteration, and result update on DONE entry only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r         <= 64'd0;
      dq_r          <= 64'd0;
      div_r         <= 64'd0;
      neg_q_r       <= 1'b0;
      neg_rem_r     <= 1'b0;
      cnt_r         <= 7'd0;
      quotient_r    <= 64'd0;
      remainder_r   <= 64'd0;
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else if (accept_s) begin
      acc_r     <= 64'd0;
      dq_r      <= cond_negate(dividend, a_neg_s);
      div_r     <= cond_negate(divisor, b_neg_s);
      neg_q_r   <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      cnt_r     <= 7'd0;
      if (zero_div_s) begin
        quotient_r    <= ALL_ONES;
        remainder_r   <= dividend;
        div_by_zero_r <= 1'b1;
        overflow_r    <= 1'b0;
      end else if (ovf_case_s) begin
        quotient_r    <= MIN_NEG;
        remainder_r   <= 64'd0;
        div_by_zero_r <= 1'b0;
        overflow_r    <= 1'b1;
      end
    end else if (state_r == CALC) begin
      // dq_r shifts dividend bits out of the top and quotient bits in at the bottom.
      acc_r <= q_bit_s ? diff_s[63:0] : shifted_s[63:0];
      dq_r  <= {dq_r[62:0], q_bit_s};
      cnt_r <= cnt_r + 7'd1;
    end else if (state_r == FIX) begin
      quotient_r    <= cond_negate(dq_r, neg_q_r);
      remainder_r   <= cond_negate(acc_r, neg_rem_r);
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_seq_divider_64.sv
// Randomized bench for seq_divider_64: an arithmetic reference model predicts every
// output each cycle, plus directed cases with hand-computed expectations.
module tb_seq_divider_64;

  localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  int   m_left = 0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;
  res_t e_res = '0;
  res_t pend = '0;

  seq_divider_64 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_div(input logic [63:0] a, input logic [63:0] b, input logic s);
    res_t o;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    o  = '0;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      o.q = ALL_ONES; o.r = a; o.dbz = 1'b1;
    end else if (s && a == MIN_NEG && b == ALL_ONES) begin
      o.q = MIN_NEG; o.r = 64'd0; o.ovf = 1'b1;
    end else if (s) begin
      o.q = sa / sb; o.r = sa % sb;
    end else begin
      o.q = a / b; o.r = a % b;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: latency bookkeeping plus arithmetic results.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; e_busy = 1'b0; e_done = 1'b0; e_res = '0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_busy = 1'b0; e_done = 1'b1; e_res = pend;
        end else begin
          e_busy = 1'b1; e_done = 1'b0;
        end
      end else if (start) begin
        pend = ref_div(dividend, divisor, is_signed);
        if (pend.dbz || pend.ovf) begin
          e_res = pend; e_done = 1'b1; e_busy = 1'b0;
        end else begin
          m_left = 65; e_busy = 1'b1; e_done = 1'b0;
        end
      end else begin
        e_busy = 1'b0; e_done = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", {63'd0, busy}, {63'd0, e_busy});
        check("done", {63'd0, done}, {63'd0, e_done});
        check("quotient", quotient, e_res.q);
        check("remainder", remainder, e_res.r);
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e_res.dbz});
        check("overflow", {63'd0, overflow}, {63'd0, e_res.ovf});
      end
    end
  end

  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic s);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int hold;
    int gap;
    int sel;
    logic [63:0] a;
    logic [63:0] b;
    logic s;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_quotient", quotient, 64'd0);
    check("reset_remainder", remainder, 64'd0);

    // Unsigned 100/7, started in the first cycle after reset release.
    rst_n = 1'b1;
    launch(64'd100, 64'd7, 1'b0);
    wait_done(lat);
    check("lat_100_7", 64'(lat), 64'd66);
    check("q_100_7", quotient, 64'd14);
    check("r_100_7", remainder, 64'd2);
    check("model_q_100_7", e_res.q, 64'd14);

    // Signed -7/2.
    launch(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    wait_done(lat);
    check("lat_m7_2", 64'(lat), 64'd66);
    check("q_m7_2", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    check("r_m7_2", remainder, ALL_ONES);
    check("model_r_m7_2", e_res.r, ALL_ONES);

    // Divide by zero.
    launch(64'h1234, 64'd0, 1'b0);
    wait_done(lat);
    check("lat_dbz", 64'(lat), 64'd1);
    check("q_dbz", quotient, ALL_ONES);
    check("r_dbz", remainder, 64'h1234);
    check("flag_dbz", {63'd0, div_by_zero}, 64'd1);

    // Signed overflow.
    launch(MIN_NEG, ALL_ONES, 1'b1);
    wait_done(lat);
    check("lat_ovf", 64'(lat), 64'd1);
    check("q_ovf", quotient, MIN_NEG);
    check("r_ovf", remainder, 64'd0);
    check("flag_ovf", {63'd0, overflow}, 64'd1);

    // Reset in the middle of a calculation, then a fresh 9/3.
    launch(64'd100, 64'd7, 1'b0);
    repeat (29) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_q", quotient, 64'd0);
    rst_n = 1'b1;
    launch(64'd9, 64'd3, 1'b0);
    wait_done(lat);
    check("lat_9_3", 64'(lat), 64'd66);
    check("q_9_3", quotient, 64'd3);
    check("r_9_3", remainder, 64'd0);

    // Ignored start mid-CALC, then start held through DONE for back-to-back.
    launch(ALL_ONES, 64'd1, 1'b0);
    repeat (9) @(posedge clk); #1;
    dividend = 64'd5; divisor = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk); #1;
    dividend = 64'd1000; divisor = 64'd10; start = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("b2b_first_done", {63'd0, done}, 64'd1);
    check("b2b_first_q", quotient, ALL_ONES);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("lat_b2b_second", 64'(lat), 64'd66);
    check("q_b2b_second", quotient, 64'd100);

    // Randomized operations with random hold/gap timing.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      a = {$urandom(), $urandom()};
      s = 1'($urandom_range(0, 1));
      case (sel)
        0: b = 64'd0;
        1: begin a = MIN_NEG; b = ALL_ONES; s = 1'b1; end
        2: begin
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
        end
        3: b = {32'd0, $urandom()};
        4: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        default: b = {$urandom(), $urandom()};
      endcase
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70)) : 1;
      repeat (hold) @(posedge clk);
      #1;
      start = 1'b0;
      gap = int'($urandom_range(0, 70));
      repeat (gap) @(posedge clk);
      #1;
    end

    repeat (80) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
